// File: rtl/mul_seq_ctrl.sv
// Sequential WxW unsigned multiplier: steps all byte pairs through one shared 8x8 multiplier.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN skips byte pairs whose product is known to be zero.

module wallace_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

module mul_seq_ctrl #(
  parameter  int W  = 16,
  localparam int NB = W / 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           busy
);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = 2 * W;

  if (W != 8 && W != 16 && W != 24 && W != 32) begin : g_bad_w
    $error("mul_seq_ctrl: W must be 8, 16, 24 or 32");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_n;
  logic [W-1:0]    op_a, op_b;
  logic [PW-1:0]   acc, res;
  logic [IW-1:0]   i, j, i_n, j_n;
  logic [7:0]      byte_a, byte_b;
  logic [15:0]     prod;
  logic [PW-1:0]   partial, acc_sum;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam int KW = (NB > 1) ? $clog2(NB * NB) : 1;
  logic [KW:0] nxt;

  // Returns {found, index} of the first row-major pair at or after start with both bytes non-zero.
  function automatic logic [KW:0] find_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int start);
    logic [KW:0] r;
    r = '0;
    for (int k = NB * NB - 1; k >= 0; k--) begin
      if (k >= start && a[8*(k/NB) +: 8] != 8'd0 && b[8*(k%NB) +: 8] != 8'd0)
        r = {1'b1, KW'(k)};
    end
    return r;
  endfunction
`endif

  wallace_mul u_mul (.a(byte_a), .b(byte_b), .p(prod));

  always_comb begin
    byte_a  = op_a[8*i +: 8];
    byte_b  = op_b[8*j +: 8];
    partial = PW'(prod) << (8 * (int'(i) + int'(j)));
    acc_sum = acc + partial;
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
`ifdef MUL_SEQ_ZERO_SKIP_EN
    nxt     = '0;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MUL_SEQ_ZERO_SKIP_EN
          nxt = find_pair(in_a, in_b, 0);
          if (nxt[KW]) begin
            state_n = MUL;
            i_n     = IW'(nxt[KW-1:0] / NB);
            j_n     = IW'(nxt[KW-1:0] % NB);
          end else begin
            state_n = DONE;
          end
`else
          state_n = MUL;
          i_n     = '0;
          j_n     = '0;
`endif
        end
      end
      MUL: begin
`ifdef MUL_SEQ_ZERO_SKIP_EN
        nxt = find_pair(op_a, op_b, int'(i) * NB + int'(j) + 1);
        if (nxt[KW]) begin
          i_n = IW'(nxt[KW-1:0] / NB);
          j_n = IW'(nxt[KW-1:0] % NB);
        end else begin
          state_n = DONE;
        end
`else
        if (i == IW'(NB - 1) && j == IW'(NB - 1)) begin
          state_n = DONE;
        end else if (j == IW'(NB - 1)) begin
          j_n = '0;
          i_n = i + 1'b1;
        end else begin
          j_n = j + 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Datapath: operand capture, accumulation, and the held result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      res  <= '0;
      i    <= '0;
      j    <= '0;
    end else begin
      i <= i_n;
      j <= j_n;
      if (state == IDLE && in_valid) begin
        op_a <= in_a;
        op_b <= in_b;
        acc  <= '0;
        if (state_n == DONE) res <= '0;
      end
      if (state == MUL) begin
        acc <= acc_sum;
        if (state_n == DONE) res <= acc_sum;
      end
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = res;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized and directed bench for mul_seq_ctrl (W=16) against a plain-arithmetic reference model.
module tb_mul_seq_ctrl;
  localparam int W  = 16;
  localparam int NB = W / 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic           busy;

  int n_chk  = 0;
  int n_pass = 0;

  mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle in which out_valid first rises, counting the accept cycle as 0.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int nz;
    nz = 0;
    for (int ia = 0; ia < NB; ia++)
      for (int ib = 0; ib < NB; ib++)
        if (a[8*ia +: 8] != 0 && b[8*ib +: 8] != 0) nz++;
`ifdef MUL_SEQ_ZERO_SKIP_EN
    return 1 + nz;
`else
    return (nz >= 0) ? NB * NB + 1 : 0;
`endif
  endfunction

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Called at posedge+1 with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int bp, input bit noisy);
    int lat;
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = (bp == 0);
    @(posedge clk); #1;
    lat = 1;
    if (!noisy) in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_in_ready_mul"}, in_ready, 0);
      chk({tag, "_busy_mul"}, busy, 1);
      if (noisy) begin in_a = W'($urandom); in_b = W'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, out_valid, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, model_lat(a, b));
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_busy_done"}, busy, 1);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_result"}, out_result, exp);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_result"}, out_result, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);

    run_op("basic", 16'h1234, 16'h5678, 32'h06260060, 0, 1'b0);
    run_op("max_bp", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10, 1'b0);

    // Reset two cycles into an operation
    in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h0102;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", out_result, 0);
    run_op("after_rst", 16'd3, 16'd5, 32'h0000000F, 0, 1'b0);

    run_op("ignored_in", 16'h0010, 16'h0010, 32'h00000100, 2, 1'b1);
    run_op("zskip_ff", 16'h00FF, 16'h00FF, 32'h0000FE01, 0, 1'b0);
    run_op("zskip_zero", 16'h0000, 16'h1234, 32'h00000000, 1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 2) == 0) ra[8*k +: 8] = 8'h00;
        if ($urandom_range(0, 2) == 0) rb[8*k +: 8] = 8'h00;
      end
      run_op("rand", ra, rb, model_prod(ra, rb), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
